// File: rtl/axi4_lite_slave_wrapper.sv
// axi4_lite_slave_wrapper
//   AXI4-lite responder holding two SZ-bit operands (a, b) written one byte at
//   a time. Writing the last byte of b launches a sequential shift-add unsigned
//   multiplier. The 2*SZ-bit product is read back a byte at a time. Every byte
//   is served from a snapshot taken when byte 0 is read, so a multi-byte read
//   stays coherent. The write and read channels are independent FSMs.
// Ports
//   clk, _rst               clock, asynchronous active-low reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wvalid/wready     write data channel (one byte per beat)
//   bresp/bvalid/bready     write response (bresp 1 = ok, 0 = bad address)
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready read data channel (rresp 1 = ok, 0 = bad address)
//   a, b                    operand registers
//   prod                    last completed product
//   busy                    multiply in progress
//   done                    one-cycle pulse when prod updates
module axi4_lite_slave_wrapper #(
  parameter int SZ  = 32,
  parameter int ASZ = 4,
  parameter int DSZ = 8
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic [ASZ-1:0]    awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DSZ-1:0]    wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ASZ-1:0]    araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DSZ-1:0]    rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              rresp,
  output logic [SZ-1:0]     a,
  output logic [SZ-1:0]     b,
  output logic [2*SZ-1:0]   prod,
  output logic              busy,
  output logic              done
);

  localparam int             NB        = SZ / DSZ;
  localparam logic [ASZ:0]   NBYTES    = (ASZ+1)'(2*NB);
  localparam logic [ASZ-1:0] LAST_ADDR = ASZ'(2*NB-1);
  localparam int             CW        = $clog2(SZ);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(SZ-1);

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_ADDR, R_DATA}         r_state_t;
  typedef enum logic       {M_IDLE, M_RUN}          m_state_t;

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;
  m_state_t m_state, m_nxt;

  logic [ASZ-1:0]  waddr;
  logic            start_req;
  logic [2*SZ-1:0] snap;
  logic [2*SZ-1:0] mcand;
  logic [2*SZ-1:0] acc;
  logic [2*SZ-1:0] acc_nxt;
  logic [SZ-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            mult_last;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic waddr_ok, raddr_ok;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign b_hs     = bvalid & bready;
  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign waddr_ok = ({1'b0, waddr} < NBYTES);
  assign raddr_ok = ({1'b0, araddr} < NBYTES);

  // Byte sel of a product image; addresses with no matching byte yield 0.
  function automatic logic [DSZ-1:0] prod_byte(input logic [2*SZ-1:0] v,
                                                input logic [ASZ-1:0]  sel);
    logic [DSZ-1:0] r;
    r = '0;
    for (int k = 0; k < 2*NB; k++)
      if (sel == ASZ'(k)) r = v[DSZ*k +: DSZ];
    return r;
  endfunction

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) w_state <= W_ADDR;
    else       w_state <= w_nxt;

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_ADDR:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_hs)  w_nxt = W_RESP;
      W_RESP:  if (b_hs)  w_nxt = W_ADDR;
      default: w_nxt = W_ADDR;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 1'b0;
      start_req <= 1'b0;
    end else begin
      awready   <= (w_nxt == W_ADDR);
      wready    <= (w_nxt == W_DATA);
      bvalid    <= (w_nxt == W_RESP);
      start_req <= w_hs && (waddr == LAST_ADDR);
      if (w_hs) bresp <= waddr_ok;
    end

  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      waddr <= '0;
      a     <= '0;
      b     <= '0;
    end else begin
      if (aw_hs) waddr <= awaddr;
      if (w_hs)
        for (int k = 0; k < NB; k++) begin
          if (waddr == ASZ'(k))      a[DSZ*k +: DSZ] <= wdata;
          if (waddr == ASZ'(NB + k)) b[DSZ*k +: DSZ] <= wdata;
        end
    end

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) r_state <= R_ADDR;
    else       r_state <= r_nxt;

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_ADDR:  if (ar_hs) r_nxt = R_DATA;
      R_DATA:  if (r_hs)  r_nxt = R_ADDR;
      default: r_nxt = R_ADDR;
    endcase
  end

  // Byte 0 refreshes the snapshot; all other bytes come from it, so a burst
  // of reads 0..2*NB-1 sees one consistent product even if prod moves.
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rresp   <= 1'b0;
      rdata   <= '0;
      snap    <= '0;
    end else begin
      arready <= (r_nxt == R_ADDR);
      rvalid  <= (r_nxt == R_DATA);
      if (ar_hs) begin
        rresp <= raddr_ok;
        if (araddr == '0) begin
          snap  <= prod;
          rdata <= prod[DSZ-1:0];
        end else begin
          rdata <= prod_byte(snap, araddr);
        end
      end
    end

  // ---------------- multiplier ----------------
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;
  assign mult_last = (m_state == M_RUN) && !start_req && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge _rst)
    if (!_rst) m_state <= M_IDLE;
    else       m_state <= m_nxt;

  // A start request always wins, so a restart mid-run abandons the old run.
  always_comb begin
    m_nxt = m_state;
    if (start_req)      m_nxt = M_RUN;
    else if (mult_last) m_nxt = M_IDLE;
  end

  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      prod <= '0;
    end else begin
      busy <= (m_nxt == M_RUN);
      done <= mult_last;
      if (mult_last) prod <= acc_nxt;
    end

  // Working registers are only meaningful while M_RUN, so they carry no reset.
  always_ff @(posedge clk)
    if (start_req) begin
      mcand  <= {{SZ{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (m_state == M_RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end

endmodule

// File: tb/tb_axi4_lite_slave_wrapper.sv
module tb_axi4_lite_slave_wrapper;
  localparam int SZ  = 32;
  localparam int ASZ = 4;
  localparam int DSZ = 8;
  localparam int NB  = SZ / DSZ;

  logic            clk = 1'b0;
  logic            _rst = 1'b0;
  logic [ASZ-1:0]  awaddr = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DSZ-1:0]  wdata = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic            bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [ASZ-1:0]  araddr = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DSZ-1:0]  rdata;
  logic            rvalid;
  logic            rready = 1'b0;
  logic            rresp;
  logic [SZ-1:0]   a;
  logic [SZ-1:0]   b;
  logic [2*SZ-1:0] prod;
  logic            busy;
  logic            done;

  axi4_lite_slave_wrapper #(.SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), ._rst(_rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp),
    .a(a), .b(b), .prod(prod), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int last_done_cyc = -1;
  always @(negedge clk)
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end

  int vectors = 0;
  int miscompares = 0;

  logic             bresp_q[$];
  logic [DSZ:0]     rd_q[$];
  logic [SZ-1:0]    cur_a = '0;
  logic [SZ-1:0]    cur_b = '0;

  task automatic do_write(input logic [ASZ-1:0] addr, input logic [DSZ-1:0] data,
                          input int bhold, output int e0);
    int n;
    logic exp;
    bresp_q.push_back(int'(addr) < 2*NB);
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL aw_timeout awready=%b required=1", awready); end
    @(negedge clk);
    awvalid = 1'b0; wdata = data; wvalid = 1'b1;
    n = 0;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL w_timeout wready=%b required=1", wready); end
    @(negedge clk);
    wvalid = 1'b0;
    e0 = cyc;
    for (int i = 0; i < bhold; i++) begin
      vectors++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_backpressure bvalid=%b awready=%b required bvalid=1 awready=0", bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL b_timeout bvalid=%b required=1", bvalid); end
    exp = bresp_q.pop_front();
    vectors++;
    if (bresp !== exp) begin
      miscompares++;
      $display("FAIL bresp addr=%0d got=%b required=%b", addr, bresp, exp);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [ASZ-1:0] addr, input logic [DSZ-1:0] exp_data,
                         input logic exp_resp);
    int n;
    logic [DSZ:0] exp;
    rd_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL ar_timeout arready=%b required=1", arready); end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL r_timeout rvalid=%b required=1", rvalid); end
    exp = rd_q.pop_front();
    vectors++;
    if ({rresp, rdata} !== exp) begin
      miscompares++;
      $display("FAIL read addr=%0d got rresp=%b rdata=%h required rresp=%b rdata=%h",
               addr, rresp, rdata, exp[DSZ], exp[DSZ-1:0]);
    end
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic load_ops(input logic [SZ-1:0] av, input logic [SZ-1:0] bv, output int e0);
    int e;
    for (int k = 0; k < NB; k++) do_write(ASZ'(k), av[DSZ*k +: DSZ], 0, e);
    for (int k = 0; k < NB; k++) do_write(ASZ'(NB + k), bv[DSZ*k +: DSZ], 0, e);
    cur_a = av; cur_b = bv;
    e0 = e;
  endtask

  task automatic check_product(input string name, input int e0, input int start_cnt,
                               input logic [2*SZ-1:0] exp_prod);
    while (cyc < e0 + 40) @(negedge clk);
    vectors++;
    if (done_cnt !== start_cnt + 1) begin
      miscompares++;
      $display("FAIL %s_done_count got=%0d required=%0d", name, done_cnt - start_cnt, 1);
    end
    vectors++;
    if (last_done_cyc !== e0 + SZ + 1) begin
      miscompares++;
      $display("FAIL %s_done_time got=%0d required=%0d", name, last_done_cyc - e0, SZ + 1);
    end
    vectors++;
    if (prod !== exp_prod) begin
      miscompares++;
      $display("FAIL %s_prod got=%h required=%h", name, prod, exp_prod);
    end
  endtask

  task automatic read_all(input logic [2*SZ-1:0] v);
    for (int k = 0; k < 2*NB; k++) do_read(ASZ'(k), v[DSZ*k +: DSZ], 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    _rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({awready, arready, wready, bvalid, bresp, rvalid, rresp, busy, done} !== 9'b110000000) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b required=110000000",
               {awready, arready, wready, bvalid, bresp, rvalid, rresp, busy, done});
    end
    vectors++;
    if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got=%h required=00", rdata); end
    vectors++;
    if (a !== '0 || b !== '0) begin miscompares++; $display("FAIL reset_ops got a=%h b=%h required 0", a, b); end
    vectors++;
    if (prod !== '0) begin miscompares++; $display("FAIL reset_prod got=%h required=0", prod); end
    read_all('0);
  endtask

  task automatic test_basic;
    int e0, s;
    logic [2*SZ-1:0] exp;
    s = done_cnt;
    load_ops(32'h3, 32'h5, e0);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b required=1", busy); end
    exp = 64'(cur_a) * 64'(cur_b);
    check_product("basic", e0, s, exp);
    read_all(exp);
  endtask

  task automatic test_max;
    int e0, s;
    s = done_cnt;
    load_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
    check_product("max", e0, s, 64'hFFFF_FFFE_0000_0001);
    read_all(64'hFFFF_FFFE_0000_0001);
  endtask

  task automatic test_bad_addr;
    int e0, s;
    s = done_cnt;
    do_write(4'd9, 8'hAA, 5, e0);
    vectors++;
    if (a !== cur_a || b !== cur_b) begin
      miscompares++;
      $display("FAIL bad_write_ops got a=%h b=%h required a=%h b=%h", a, b, cur_a, cur_b);
    end
    do_read(4'd12, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt !== s || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_write_start got done=%0d busy=%b required done=0 busy=0", done_cnt - s, busy);
    end
  endtask

  task automatic test_snapshot;
    int e0, s;
    s = done_cnt;
    load_ops(32'h3, 32'h5, e0);
    check_product("snap_old", e0, s, 64'hF);
    do_read(4'd0, 8'h0F, 1'b1);
    s = done_cnt;
    load_ops(32'h10, 32'h10, e0);
    check_product("snap_new", e0, s, 64'h100);
    for (int k = 1; k < 2*NB; k++) do_read(ASZ'(k), 8'h00, 1'b1);
    read_all(64'h100);
  endtask

  task automatic test_restart;
    int e0, e1, s;
    logic [2*SZ-1:0] exp;
    s = done_cnt;
    load_ops(32'h7, 32'h9, e0);
    while (cyc < e0 + 10) @(negedge clk);
    do_write(ASZ'(2*NB-1), 8'h01, 0, e1);
    cur_b[SZ-1 -: DSZ] = 8'h01;
    exp = 64'(cur_a) * 64'(cur_b);
    check_product("restart", e1, s, exp);
  endtask

  task automatic test_reset_midrun;
    int e0, s;
    s = done_cnt;
    do_write(ASZ'(2*NB-1), 8'h02, 0, e0);
    while (cyc < e0 + 8) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy got=%b required=1", busy); end
    _rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || prod !== '0 || a !== '0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_reset got busy=%b prod=%h a=%h awready=%b required busy=0 prod=0 a=0 awready=1",
               busy, prod, a, awready);
    end
    @(negedge clk);
    @(negedge clk);
    _rst = 1'b1;
    repeat (45) @(negedge clk);
    vectors++;
    if (done_cnt !== s || busy !== 1'b0 || prod !== '0) begin
      miscompares++;
      $display("FAIL midrun_after got done=%0d busy=%b prod=%h required done=0 busy=0 prod=0",
               done_cnt - s, busy, prod);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_bad_addr();
    test_snapshot();
    test_restart();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_wrapper.md
# axi4_lite_slave_wrapper

AXI4-lite responder that pairs with the operand/result master wrapper. It accepts byte-wide writes that assemble two SZ-bit operands `a` and `b`. A write to the last operand byte launches a sequential shift-add unsigned multiplier. Byte-wide reads return the 2*SZ-bit product from a coherent snapshot. The write and read channels run as independent state machines, so a master can stream operands and poll results at the same time.

## Interface
- `SZ`, 32, operand width in bits
- `ASZ`, 4, address width
- `DSZ`, 8, data width; NB = SZ/DSZ bytes per operand; 2*NB ≤ 2^ASZ required
- `clk`  in  1  clock
- `_rst`  in  1  reset, asynchronous, active-low
- `awaddr`  in  ASZ  write address
- `awvalid`  in  1  write address valid
- `awready`  out  1  write address ready
- `wdata`  in  DSZ  write data
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data ready
- `bresp`  out  1  write response; 1 = ok, 0 = bad address
- `bvalid`  out  1  write response valid
- `bready`  in  1  write response ready
- `araddr`  in  ASZ  read address
- `arvalid`  in  1  read address valid
- `arready`  out  1  read address ready
- `rdata`  out  DSZ  read data
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data ready
- `rresp`  out  1  read response; 1 = ok, 0 = bad address
- `a`, `b`  out  SZ  operand registers, for debug/observation
- `prod`  out  2*SZ  last completed product
- `busy`  out  1  multiply in progress
- `done`  out  1  one-cycle pulse when `prod` updates

## Operation
**Address map**
- Write address k < NB: writes `a[DSZ*k +: DSZ]`.
- Write address NB ≤ k < 2*NB: writes `b[DSZ*(k-NB) +: DSZ]`.
- Read address k < 2*NB: returns byte k of the product; byte 0 is the least significant.
- Any address ≥ 2*NB: writes are discarded with `bresp`=0; reads return `rdata`=0 with `rresp`=0.

**Write FSM: W_ADDR → W_DATA → W_RESP → W_ADDR**
- W_ADDR: `awready`=1. On `awvalid`&`awready`, latch `awaddr`, set `awready`←0 and `wready`←1, go to W_DATA.
- W_DATA: on `wvalid`&`wready`:
  - Update the operand byte if the address is valid.
  - Set `wready`←0, `bvalid`←1, `bresp`←(addr < 2*NB).
  - Go to W_RESP.
  - If addr = 2*NB-1, raise a start request.
- W_RESP: hold `bvalid`/`bresp` until `bready`. On handshake, set `bvalid`←0 and `awready`←1, go to W_ADDR.
- Backpressure: while `bready` is low, `awready` stays 0.

**Read FSM: R_ADDR → R_DATA → R_ADDR**
- R_ADDR: `arready`=1. On `arvalid`&`arready`, set `arready`←0, `rvalid`←1, `rresp`←(addr < 2*NB), then:
  - addr 0: `snap`←`prod`, `rdata`←`prod[DSZ-1:0]`.
  - addr 1..2*NB-1: `rdata`←`snap[DSZ*addr +: DSZ]`.
  - invalid address: `rdata`←0.
- R_DATA: hold `rvalid`/`rdata`/`rresp` until `rready`. On handshake, set `rvalid`←0 and `arready`←1.
- Coherence: bytes 1..2*NB-1 always come from the snapshot taken at the most recent address-0 read. The snapshot resets to 0.

**Multiplier (M_IDLE / M_RUN)**
- Start: load `mcand`←{SZ'0, `a`}, `mplier`←`b`, `acc`←0, `cnt`←0, `busy`←1.
  - The loaded `a`/`b` include the just-written byte.
- Each RUN cycle:
  - If `mplier[0]`, `acc`←`acc`+`mcand`.
  - `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`++.
- After SZ iterations: `prod`←final `acc` (mod 2^(2*SZ), unsigned), `done`←1 for one cycle, `busy`←0.
- A start request while `busy` aborts the current run and restarts from the current operands. The aborted run produces no `done`.
- Operand writes to other bytes during RUN do not affect the run in progress.

## Timing
- Reset values:
  - `awready`=1, `arready`=1.
  - `wready`, `bvalid`, `bresp`, `rvalid`, `rresp`, `busy`, `done` = 0.
  - `rdata`, `a`, `b`, `prod`, snapshot = 0.
  - Both FSMs return to their ADDR state and any multiply in progress is abandoned.
- Write transaction: at least 3 cycles (AW, W, B handshakes on successive edges). Read transaction: at least 2 cycles.
- E0 is the edge of the W handshake to address 2*NB-1:
  - E0+1: operands loaded, `busy`=1.
  - E0+SZ+1: `prod` updated, `done` high for the following cycle (33 cycles for SZ=32).
- `prod` update on the same edge as an address-0 read: the snapshot captures the pre-edge (old) `prod`.
- Write and read handshakes on the same edge are independent and both complete.
- All outputs are registered.

## Test plan
- Reset: deassert `_rst` → `awready`=`arready`=1, all other outputs 0; reads of addresses 0..7 return 0x00 with `rresp`=1.
- Write a=0x00000003, b=0x00000005 to addresses 0..7 → each `bresp`=1. `done` pulses 33 cycles after the address-7 W handshake, `prod`=0xF. Reads of 0..7 return 0x0F, 0x00 × 7.
- a=b=0xFFFFFFFF → `prod`=0xFFFFFFFE00000001. Reads of 0..7 return 01,00,00,00,FE,FF,FF,FF.
- Write address 9 with 0xAA → `bresp`=0, `a`/`b` unchanged. Read address 12 → `rdata`=0, `rresp`=0. Hold `bready`=0 for 5 cycles → `bvalid` held, `awready`=0.
- Snapshot coherence: with `prod`=0xF, read address 0; then complete a product of 0x100 (a=0x10, b=0x10); then read 1..7 → all 0x00 from the old snapshot. The next address-0 read returns 0x00 and addresses 1..7 follow 0x100 (byte 1 = 0x01).
- Restart and reset:
  - Rewrite address 7 ten cycles into a run → exactly one `done`, 33 cycles after the second write, with the new product.
  - Assert `_rst` mid-run → `busy`=0, `prod`=0, no `done`.
